prog_sequencer: RTL

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_seq_pkg.sv | 24 ++
 rtl/seq_cycle_counter.sv | 23 ++
 rtl/prog_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer and its cycle counter.
// Program IDs double as the ProgState encoding seen by the fetch stage.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [1:0] PROG_0    = 2'd0;
  localparam logic [1:0] PROG_1    = 2'd1;
  localparam logic [1:0] PROG_2    = 2'd2;
  localparam logic [1:0] PROG_NONE = 2'b11;

  localparam int CNT_W = 16;

  // A lone program request must name a real program; a RunAll request always does.
  function automatic logic start_valid(input logic run_all, input logic [1:0] sel);
    return run_all || (sel != PROG_NONE);
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Saturating RUN-cycle counter with synchronous clear and count enable.
// Clear has priority over enable; the count parks at all-ones.
module seq_cycle_counter
  import prog_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Launches fetch-stage programs (one, or 0..2 back-to-back) and watches each for Halt or timeout.
// Outputs are registered from the next-state decode, so they line up with the state they describe.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter logic [15:0] MAX_CYCLES = 16'd1000
) (
  input  logic        CLK,
  input  logic        Init_n,
  input  logic        Start,
  input  logic        RunAll,
  input  logic [1:0]  ProgSel,
  input  logic        Halt,
  output logic        Init,
  output logic [1:0]  ProgState,
  output logic        Busy,
  output logic        Done,
  output logic        TimedOut,
  output logic [15:0] CycleCount,
  output logic [2:0]  ProgDoneMask
);

  state_t      state, state_nxt;
  logic [1:0]  prog, prog_nxt;
  logic        run_all, run_all_nxt;
  logic        first_run;
  logic        accept, halt_fin, tmo_fin;

  logic        init_nxt, busy_nxt, done_nxt, tmo_nxt;
  logic [1:0]  prog_state_nxt;
  logic [2:0]  mask_nxt;

  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      state     <= ST_IDLE;
      prog      <= PROG_NONE;
      run_all   <= 1'b0;
      first_run <= 1'b0;
    end else begin
      state     <= state_nxt;
      prog      <= prog_nxt;
      run_all   <= run_all_nxt;
      first_run <= (state == ST_LOAD);
    end
  end

  always_comb begin
    state_nxt   = state;
    prog_nxt    = prog;
    run_all_nxt = run_all;
    accept      = 1'b0;
    halt_fin    = 1'b0;
    tmo_fin     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start && start_valid(RunAll, ProgSel)) begin
          accept      = 1'b1;
          state_nxt   = ST_LOAD;
          prog_nxt    = RunAll ? PROG_0 : ProgSel;
          run_all_nxt = RunAll;
        end
      end
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN: begin
        // Halt seen alongside Init is stale from the previous program.
        if (Halt && !first_run) begin
          halt_fin  = 1'b1;
          state_nxt = ST_FINISH;
        end else if (CycleCount == (MAX_CYCLES - 16'd1)) begin
          tmo_fin   = 1'b1;
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (run_all && (prog != PROG_2)) begin
          state_nxt = ST_LOAD;
          prog_nxt  = prog + 2'd1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    init_nxt       = (state_nxt == ST_LOAD);
    busy_nxt       = (state_nxt != ST_IDLE);
    done_nxt       = (state_nxt == ST_FINISH);
    prog_state_nxt = (state_nxt == ST_IDLE) ? PROG_NONE : prog_nxt;
    tmo_nxt        = TimedOut;
    if (state_nxt == ST_LOAD) begin
      tmo_nxt = 1'b0;
    end else if (halt_fin || tmo_fin) begin
      tmo_nxt = tmo_fin;
    end
    mask_nxt = accept ? 3'b000 : ProgDoneMask;
    if (halt_fin) begin
      mask_nxt = mask_nxt | (3'b001 << prog);
    end
  end

  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      Init         <= 1'b0;
      ProgState    <= PROG_NONE;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      TimedOut     <= 1'b0;
      ProgDoneMask <= 3'b000;
    end else begin
      Init         <= init_nxt;
      ProgState    <= prog_state_nxt;
      Busy         <= busy_nxt;
      Done         <= done_nxt;
      TimedOut     <= tmo_nxt;
      ProgDoneMask <= mask_nxt;
    end
  end

  seq_cycle_counter u_cycle_counter (
    .clk    (CLK),
    .rst_n  (Init_n),
    .clear  (state_nxt == ST_LOAD),
    .enable (state_nxt == ST_RUN),
    .count  (CycleCount)
  );

endmodule
